uart_echo_checker: RTL and testbench

- Synthesizable, parametrised UART traffic generator and echo checker for CPU serial-echo self-test, on-chip or in simulation.
- Transmits NUM_CHARS characters from an arithmetic sequence, receives the DUT's echoes concurrently, compares them in order, and reports pass, fail or timeout.
- Sits between a test controller and the CPU serial pins; serial_out drives the CPU serial_in, serial_in samples the CPU serial_out.

---
 rtl/uart_echo_checker.sv | 212 +++++++++++++++++++++
 tb/tb_uart_echo_checker.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/uart_echo_checker.sv
// UART traffic generator and in-order echo checker for CPU serial self-test.
// Define UART_ECHO_PARITY_EN to add an even-parity bit to every frame (11-bit frames).
module uart_echo_checker #(
  parameter int          CLOCK_FREQ     = 50_000_000,
  parameter int          BAUD_RATE      = 1_000_000,
  parameter int          NUM_CHARS      = 200,
  parameter logic [7:0]  CHAR0          = 8'h61,
  parameter logic [7:0]  CHAR_STEP      = 8'd1,
  parameter int          GAP_CYCLES     = 100,
  parameter int          TIMEOUT_CYCLES = 10_000_000,
  parameter int          CNT_W          = $clog2(NUM_CHARS + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic             serial_out,
  input  logic             serial_in,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic             timeout,
  output logic [CNT_W-1:0] rx_count,
  output logic [CNT_W-1:0] mismatch_count,
  output logic [CNT_W-1:0] first_mismatch_idx,
  output logic             err_pulse
);
  localparam int CLKS_PER_BIT = CLOCK_FREQ / BAUD_RATE;
  localparam int HALF_BIT     = CLKS_PER_BIT / 2;
  localparam int CMAX         = (CLKS_PER_BIT > GAP_CYCLES) ? CLKS_PER_BIT : GAP_CYCLES;
  localparam int CW           = $clog2(CMAX + 1);
  localparam int TW           = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_PAR, TX_STOP, TX_GAP, TX_DONE} tx_state_t;
  typedef enum logic [2:0] {RX_IDLE, RX_START_CHK, RX_DATA, RX_PAR, RX_STOP} rx_state_t;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  logic [1:0] rst_pipe;
  logic       arst_n;
  tx_state_t  tx_state, tx_next;
  rx_state_t  rx_state, rx_next;
  logic [CW-1:0]    tx_cnt, rx_cnt;
  logic [2:0]       tx_bit, rx_bit;
  logic [CNT_W-1:0] tx_idx;
  logic [7:0]       tx_char, rx_shift, rx_exp;
  logic [TW-1:0]    timer;
  logic [1:0]       rx_sync;
  logic tx_wrap, rx_wrap, tx_line, rx_line, rx_prev;
  logic start_acc, finish, timer_hit, abort, frame_done, bad, par_err;

  // Reset asserts at once, releases only on a clock edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rst_pipe <= 2'b00;
    else        rst_pipe <= {rst_pipe[0], 1'b1};
  end
  assign arst_n = rst_pipe[1];

  assign start_acc = start && !busy;
  assign finish    = busy && (tx_state == TX_DONE) && (rx_count == CNT_W'(NUM_CHARS));
  assign timer_hit = busy && (timer == TW'(TIMEOUT_CYCLES - 1));
  assign abort     = timer_hit && !finish;
  assign tx_wrap   = (tx_state == TX_GAP) ? (tx_cnt == CW'(GAP_CYCLES - 1))
                                          : (tx_cnt == CW'(CLKS_PER_BIT - 1));

  always_comb begin
    tx_next = tx_state;
    tx_line = 1'b1;
    case (tx_state)
      TX_IDLE:  if (start_acc) tx_next = TX_START;
      TX_START: begin
        tx_line = 1'b0;
        if (tx_wrap) tx_next = TX_DATA;
      end
      TX_DATA: begin
        tx_line = tx_char[tx_bit];
`ifdef UART_ECHO_PARITY_EN
        if (tx_wrap && tx_bit == 3'd7) tx_next = TX_PAR;
`else
        if (tx_wrap && tx_bit == 3'd7) tx_next = TX_STOP;
`endif
      end
      TX_PAR: begin
        tx_line = ^tx_char;
        if (tx_wrap) tx_next = TX_STOP;
      end
      TX_STOP:  if (tx_wrap) tx_next = TX_GAP;
      TX_GAP:   if (tx_wrap) tx_next = (tx_idx < CNT_W'(NUM_CHARS)) ? TX_START : TX_DONE;
      TX_DONE:  if (finish) tx_next = TX_IDLE;
      default:  tx_next = TX_IDLE;
    endcase
    if (abort) tx_next = TX_IDLE;
  end

  // serial_out is the registered copy of tx_line, so every bit lasts CLKS_PER_BIT on the wire.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      tx_state   <= TX_IDLE;
      tx_cnt     <= '0;
      tx_bit     <= '0;
      tx_idx     <= '0;
      serial_out <= 1'b1;
    end else begin
      tx_state   <= tx_next;
      tx_cnt     <= (tx_wrap || tx_next != tx_state) ? '0 : tx_cnt + 1'b1;
      tx_bit     <= (tx_state != TX_DATA) ? '0 : (tx_wrap ? tx_bit + 1'b1 : tx_bit);
      serial_out <= abort ? 1'b1 : tx_line;
      if (start_acc)                        tx_idx <= '0;
      else if (tx_state == TX_STOP && tx_wrap) tx_idx <= sat_inc(tx_idx);
    end
  end

  always_ff @(posedge clk) begin
    if (start_acc)                           tx_char <= CHAR0;
    else if (tx_state == TX_STOP && tx_wrap) tx_char <= tx_char + CHAR_STEP;
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      rx_sync <= 2'b11;
      rx_prev <= 1'b1;
    end else begin
      rx_sync <= {rx_sync[0], serial_in};
      rx_prev <= rx_sync[1];
    end
  end
  assign rx_line = rx_sync[1];
  assign rx_wrap = (rx_state == RX_START_CHK) ? (rx_cnt == CW'(HALF_BIT - 1))
                                              : (rx_cnt == CW'(CLKS_PER_BIT - 1));

  always_comb begin
    rx_next    = rx_state;
    frame_done = 1'b0;
    case (rx_state)
      RX_IDLE:      if (rx_prev && !rx_line) rx_next = RX_START_CHK;
      RX_START_CHK: if (rx_wrap) rx_next = rx_line ? RX_IDLE : RX_DATA;
`ifdef UART_ECHO_PARITY_EN
      RX_DATA:      if (rx_wrap && rx_bit == 3'd7) rx_next = RX_PAR;
`else
      RX_DATA:      if (rx_wrap && rx_bit == 3'd7) rx_next = RX_STOP;
`endif
      RX_PAR:       if (rx_wrap) rx_next = RX_STOP;
      RX_STOP: begin
        if (rx_wrap) begin
          frame_done = 1'b1;
          rx_next    = RX_IDLE;
        end
      end
      default:      rx_next = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      rx_state <= RX_IDLE;
      rx_cnt   <= '0;
      rx_bit   <= '0;
    end else begin
      rx_state <= rx_next;
      rx_cnt   <= (rx_wrap || rx_next != rx_state) ? '0 : rx_cnt + 1'b1;
      rx_bit   <= (rx_state != RX_DATA) ? '0 : (rx_wrap ? rx_bit + 1'b1 : rx_bit);
    end
  end

`ifdef UART_ECHO_PARITY_EN
  logic rx_par;
  always_ff @(posedge clk) begin
    if (rx_state == RX_PAR && rx_wrap) rx_par <= rx_line;
  end
  assign par_err = (^rx_shift) != rx_par;
`else
  assign par_err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rx_state == RX_DATA && rx_wrap) rx_shift <= {rx_line, rx_shift[7:1]};
    if (start_acc)                      rx_exp   <= CHAR0;
    else if (busy && frame_done)        rx_exp   <= rx_exp + CHAR_STEP;
  end

  // rx_line here is the stop-bit sample taken on this same cycle.
  assign bad = (rx_shift != rx_exp) || !rx_line || par_err;

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      busy <= 1'b0; done <= 1'b0; pass <= 1'b0; timeout <= 1'b0; err_pulse <= 1'b0;
      rx_count <= '0; mismatch_count <= '0; first_mismatch_idx <= '1; timer <= '0;
    end else begin
      err_pulse <= 1'b0;
      if (start_acc) begin
        busy <= 1'b1; done <= 1'b0; pass <= 1'b0; timeout <= 1'b0;
        rx_count <= '0; mismatch_count <= '0; first_mismatch_idx <= '1; timer <= '0;
      end else if (busy) begin
        timer <= timer + 1'b1;
        if (frame_done) begin
          rx_count <= sat_inc(rx_count);
          if (bad) begin
            mismatch_count <= sat_inc(mismatch_count);
            err_pulse      <= 1'b1;
            if (&first_mismatch_idx) first_mismatch_idx <= rx_count;
          end
        end
        if (finish) begin
          busy <= 1'b0; done <= 1'b1; pass <= (mismatch_count == '0);
        end else if (timer_hit) begin
          busy <= 1'b0; done <= 1'b1; timeout <= 1'b1; pass <= 1'b0;
        end
      end
    end
  end
endmodule

// File: tb/tb_uart_echo_checker.sv
// Directed bench for uart_echo_checker: loopback, corrupted echo, timeout, framing/glitch, reset.
module tb_uart_echo_checker;
`ifdef UART_ECHO_PARITY_EN
  localparam int FRAME_BITS = 11;
`else
  localparam int FRAME_BITS = 10;
`endif
  localparam int BIT      = 50;
  localparam int PERIOD   = FRAME_BITS * BIT + 100;
  localparam int DONE_REL = 4 * PERIOD + 1;

  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0;
  logic serial_out, serial_in, busy, done, pass, timeout, err_pulse;
  logic [2:0] rx_count, mismatch_count, first_mismatch_idx;
  int cyc = 0, s = 0, n_checks = 0, n_fail = 0, n_err = 0, err_base = 0;
  logic flip_en = 1'b0, glitch_en = 1'b0, hold_high = 1'b0, flip_win, glitch_win;
  int flip_lo = 0, flip_hi = 0, gl_lo = 0, gl_hi = 0;

  uart_echo_checker #(
    .CLOCK_FREQ(50_000_000), .BAUD_RATE(1_000_000), .NUM_CHARS(4), .CHAR0(8'h61),
    .CHAR_STEP(8'd1), .GAP_CYCLES(100), .TIMEOUT_CYCLES(5000)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .serial_out(serial_out), .serial_in(serial_in),
    .busy(busy), .done(done), .pass(pass), .timeout(timeout), .rx_count(rx_count),
    .mismatch_count(mismatch_count), .first_mismatch_idx(first_mismatch_idx), .err_pulse(err_pulse)
  );

  always #10 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (err_pulse === 1'b1) n_err <= n_err + 1;

  always_comb begin
    flip_win   = flip_en && ((cyc - s) >= flip_lo) && ((cyc - s) <= flip_hi);
    glitch_win = glitch_en && ((cyc - s) >= gl_lo) && ((cyc - s) <= gl_hi);
  end
  assign serial_in = hold_high | (~glitch_win & (serial_out ^ flip_win));

  task automatic pulse_start();
    @(negedge clk); start = 1'b1;
    @(posedge clk); #1; s = cyc; start = 1'b0;
    err_base = n_err;
  endtask

  task automatic wait_rel(input int n);
    while ((cyc - s) < n) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk); #1;
    n_checks++; if (serial_out !== 1'b1) begin n_fail++; $display("FAIL rst_serial_out: got %b want 1", serial_out); end
    @(negedge clk) rst_n = 1'b1;
    repeat (5) @(posedge clk); #1;
    n_checks++; if ({busy, done, pass, timeout, err_pulse} !== 5'b0) begin n_fail++; $display("FAIL rst_flags: got %b want 00000", {busy, done, pass, timeout, err_pulse}); end
    n_checks++; if ({rx_count, mismatch_count} !== 6'b0) begin n_fail++; $display("FAIL rst_counts: got %b want 000000", {rx_count, mismatch_count}); end
    n_checks++; if (first_mismatch_idx !== 3'b111) begin n_fail++; $display("FAIL rst_first_idx: got %b want 111", first_mismatch_idx); end
  endtask

  task automatic test_loopback();
    pulse_start();
    n_checks++; if ({busy, serial_out} !== 2'b11) begin n_fail++; $display("FAIL lb_busy_rise: got %b want 11", {busy, serial_out}); end
    wait_rel(1);
    n_checks++; if (serial_out !== 1'b0) begin n_fail++; $display("FAIL lb_first_start_bit: got %b want 0", serial_out); end
    wait_rel(DONE_REL - 1);
    n_checks++; if ({busy, done} !== 2'b10) begin n_fail++; $display("FAIL lb_before_done: got %b want 10", {busy, done}); end
    wait_rel(DONE_REL);
    n_checks++; if ({busy, done, pass, timeout} !== 4'b0110) begin n_fail++; $display("FAIL lb_done_flags: got %b want 0110", {busy, done, pass, timeout}); end
    n_checks++; if (rx_count !== 3'd4) begin n_fail++; $display("FAIL lb_rx_count: got %0d want 4", rx_count); end
    n_checks++; if (mismatch_count !== 3'd0) begin n_fail++; $display("FAIL lb_mismatch: got %0d want 0", mismatch_count); end
    n_checks++; if (first_mismatch_idx !== 3'b111) begin n_fail++; $display("FAIL lb_first_idx: got %b want 111", first_mismatch_idx); end
    n_checks++; if (n_err - err_base !== 0) begin n_fail++; $display("FAIL lb_err_pulses: got %0d want 0", n_err - err_base); end
  endtask

  task automatic test_mismatch();
    flip_lo = 1 + 2 * PERIOD + BIT; flip_hi = flip_lo + BIT - 1;
    pulse_start(); flip_en = 1'b1;
    wait_rel(DONE_REL);
    flip_en = 1'b0;
    n_checks++; if ({done, pass, timeout} !== 3'b100) begin n_fail++; $display("FAIL mm_flags: got %b want 100", {done, pass, timeout}); end
    n_checks++; if (rx_count !== 3'd4) begin n_fail++; $display("FAIL mm_rx_count: got %0d want 4", rx_count); end
    n_checks++; if (mismatch_count !== 3'd1) begin n_fail++; $display("FAIL mm_count: got %0d want 1", mismatch_count); end
    n_checks++; if (first_mismatch_idx !== 3'd2) begin n_fail++; $display("FAIL mm_first_idx: got %0d want 2", first_mismatch_idx); end
    n_checks++; if (n_err - err_base !== 1) begin n_fail++; $display("FAIL mm_err_pulses: got %0d want 1", n_err - err_base); end
  endtask

  task automatic test_timeout();
    hold_high = 1'b1;
    pulse_start();
    wait_rel(4999);
    n_checks++; if ({busy, timeout, done} !== 3'b100) begin n_fail++; $display("FAIL to_before: got %b want 100", {busy, timeout, done}); end
    wait_rel(5000);
    n_checks++; if ({busy, done, pass, timeout} !== 4'b0101) begin n_fail++; $display("FAIL to_flags: got %b want 0101", {busy, done, pass, timeout}); end
    n_checks++; if (rx_count !== 3'd0) begin n_fail++; $display("FAIL to_rx_count: got %0d want 0", rx_count); end
    n_checks++; if (serial_out !== 1'b1) begin n_fail++; $display("FAIL to_serial_out: got %b want 1", serial_out); end
    hold_high = 1'b0;
  endtask

  task automatic test_framing_glitch();
    flip_lo = 1 + (FRAME_BITS - 1) * BIT; flip_hi = flip_lo + BIT - 1;
    gl_lo = FRAME_BITS * BIT + 20; gl_hi = gl_lo + 19;
    pulse_start(); flip_en = 1'b1; glitch_en = 1'b1;
    wait_rel(DONE_REL);
    flip_en = 1'b0; glitch_en = 1'b0;
    n_checks++; if ({done, pass, timeout} !== 3'b100) begin n_fail++; $display("FAIL fr_flags: got %b want 100", {done, pass, timeout}); end
    n_checks++; if (rx_count !== 3'd4) begin n_fail++; $display("FAIL fr_rx_count: got %0d want 4", rx_count); end
    n_checks++; if (mismatch_count !== 3'd1) begin n_fail++; $display("FAIL fr_count: got %0d want 1", mismatch_count); end
    n_checks++; if (first_mismatch_idx !== 3'd0) begin n_fail++; $display("FAIL fr_first_idx: got %0d want 0", first_mismatch_idx); end
    n_checks++; if (n_err - err_base !== 1) begin n_fail++; $display("FAIL fr_err_pulses: got %0d want 1", n_err - err_base); end
  endtask

  task automatic test_reset_mid_frame();
    pulse_start();
    wait_rel(PERIOD + BIT + 10);
    n_checks++; if (serial_out !== 1'b0) begin n_fail++; $display("FAIL mr_data_bit: got %b want 0", serial_out); end
    n_checks++; if (rx_count !== 3'd1) begin n_fail++; $display("FAIL mr_rx_before: got %0d want 1", rx_count); end
    #2 rst_n = 1'b0;
    #1;
    n_checks++; if (serial_out !== 1'b1) begin n_fail++; $display("FAIL mr_serial_out: got %b want 1", serial_out); end
    n_checks++; if ({busy, done, pass, timeout, err_pulse} !== 5'b0) begin n_fail++; $display("FAIL mr_flags: got %b want 00000", {busy, done, pass, timeout, err_pulse}); end
    n_checks++; if ({rx_count, mismatch_count} !== 6'b0) begin n_fail++; $display("FAIL mr_counts: got %b want 000000", {rx_count, mismatch_count}); end
    n_checks++; if (first_mismatch_idx !== 3'b111) begin n_fail++; $display("FAIL mr_first_idx: got %b want 111", first_mismatch_idx); end
    @(negedge clk) rst_n = 1'b1;
    repeat (5) @(posedge clk);
  endtask

  task automatic test_back_to_back();
    pulse_start();
    wait_rel(PERIOD + 100);
    n_checks++; if (rx_count !== 3'd1) begin n_fail++; $display("FAIL bb_rx_before: got %0d want 1", rx_count); end
    @(negedge clk) start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    @(posedge clk); #1;
    n_checks++; if ({busy, rx_count} !== 4'b1001) begin n_fail++; $display("FAIL bb_ignored: got %b want 1001", {busy, rx_count}); end
    wait_rel(DONE_REL);
    n_checks++; if ({busy, done, pass, timeout} !== 4'b0110) begin n_fail++; $display("FAIL bb_flags: got %b want 0110", {busy, done, pass, timeout}); end
    n_checks++; if ({rx_count, mismatch_count} !== 6'b100000) begin n_fail++; $display("FAIL bb_counts: got %b want 100000", {rx_count, mismatch_count}); end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_loopback();
    test_mismatch();
    test_timeout();
    test_framing_glitch();
    test_reset_mid_frame();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
